// File: rtl/pu_pkg.sv
// Shared types, constants and helpers for the pipelined floating-point dot-product unit.
// Lane slice helper: lane i of a packed multi-lane bus of width w per lane.
`define PU_LANE(bus, i, w) bus[(i)*(w) +: (w)]

package pu_pkg;

  localparam logic [63:0] FP_ZERO = 64'h0;

  typedef enum logic {
    ACC_EMPTY = 1'b0,
    ACC_BUSY  = 1'b1
  } acc_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int tree_levels(input int lanes);
    return clog2(lanes);
  endfunction

  // Exponent width of the IEEE-754 format matching a word width.
  function automatic int exp_width(input int xlen);
    case (xlen)
      16:      return 5;
      64:      return 11;
      default: return 8;
    endcase
  endfunction

endpackage

// File: rtl/pu_if.sv
// Stream bus of the dot-product unit: beat input side and result output side.
interface pu_if #(
  parameter int XLEN  = 32,
  parameter int LANES = 4,
  parameter int CNT_W = 8
);
  logic [LANES*XLEN-1:0] in_num;
  logic [LANES*XLEN-1:0] in_weight;
  logic                  in_valid;
  logic                  in_last;
  logic                  in_ready;
  logic [XLEN-1:0]       result;
  logic                  out_valid;
  logic                  out_ready;
  logic [CNT_W-1:0]      beat_count;

  // A beat transfers on a rising edge with in_valid && in_ready, a result with
  // out_valid && out_ready; once raised, valid and its payload hold until that edge.
  modport slave (
    input  in_num, in_weight, in_valid, in_last, out_ready,
    output in_ready, result, out_valid, beat_count
  );

  modport master (
    output in_num, in_weight, in_valid, in_last, out_ready,
    input  in_ready, result, out_valid, beat_count
  );
endinterface

// File: rtl/fp_adder_tree_level.sv
// One registered level of the adder tree: pairs adjacent lanes and halves the lane count.
module fp_adder_tree_level #(
  parameter int XLEN = 32,
  parameter int N_IN = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_en,
  input  logic [N_IN*XLEN-1:0]       i_data,
  input  logic                       i_valid,
  input  logic                       i_last,
  output logic [(N_IN/2)*XLEN-1:0]   o_data,
  output logic                       o_valid,
  output logic                       o_last
);
  localparam int N_OUT = N_IN / 2;

  logic [N_OUT*XLEN-1:0] w_sum;
  logic [N_OUT*XLEN-1:0] r_data;
  logic                  r_valid;
  logic                  r_last;

  for (genvar j = 0; j < N_OUT; j++) begin : g_add
    FloatingAddition #(.XLEN(XLEN)) u_add (
      .i_a      (`PU_LANE(i_data, 2*j, XLEN)),
      .i_b      (`PU_LANE(i_data, 2*j+1, XLEN)),
      .o_result (`PU_LANE(w_sum, j, XLEN))
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (i_en) begin
      r_data  <= w_sum;
      r_valid <= i_valid;
      r_last  <= i_last;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_last  = r_last;
endmodule

// File: rtl/fp_cores.sv
// Combinational IEEE-754 multiply and add cores shared across the datapath.
// Subnormals flush to zero, results truncate toward zero, NaN is the canonical quiet NaN.
module FloatingMultiplication import pu_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_result
);
  localparam int EW   = exp_width(XLEN);
  localparam int MW   = XLEN - 1 - EW;
  localparam int BIAS = (1 << (EW - 1)) - 1;
  localparam int EMAX = (1 << EW) - 1;

  logic [EW-1:0]     w_ea, w_eb;
  logic              w_a_zero, w_b_zero, w_a_spec, w_b_spec, w_nan;
  logic [2*MW+1:0]   w_prod;
  logic [MW-1:0]     w_frac;
  int                w_exp;
  logic              w_unused;

  assign w_ea     = i_a[XLEN-2 -: EW];
  assign w_eb     = i_b[XLEN-2 -: EW];
  assign w_a_zero = (w_ea == '0);
  assign w_b_zero = (w_eb == '0);
  assign w_a_spec = (w_ea == '1);
  assign w_b_spec = (w_eb == '1);
  assign w_nan    = (w_a_spec && i_a[MW-1:0] != '0) || (w_b_spec && i_b[MW-1:0] != '0) ||
                    (w_a_spec && w_b_zero) || (w_b_spec && w_a_zero);
  assign w_prod   = {{(MW+1){1'b0}}, 1'b1, i_a[MW-1:0]} * {{(MW+1){1'b0}}, 1'b1, i_b[MW-1:0]};
  assign w_unused = ^w_prod[MW-1:0];

  always_comb begin
    if (w_prod[2*MW+1]) begin
      w_frac = w_prod[2*MW -: MW];
      w_exp  = int'(w_ea) + int'(w_eb) - BIAS + 1;
    end else begin
      w_frac = w_prod[2*MW-1 -: MW];
      w_exp  = int'(w_ea) + int'(w_eb) - BIAS;
    end
    o_result = {i_a[XLEN-1] ^ i_b[XLEN-1], EW'(w_exp), w_frac};
    if (w_nan)
      o_result = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
    else if (w_a_spec || w_b_spec || w_exp >= EMAX)
      o_result = {i_a[XLEN-1] ^ i_b[XLEN-1], {EW{1'b1}}, {MW{1'b0}}};
    else if (w_a_zero || w_b_zero || w_exp <= 0)
      o_result = {i_a[XLEN-1] ^ i_b[XLEN-1], {(XLEN-1){1'b0}}};
  end
endmodule

module FloatingAddition import pu_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_result
);
  localparam int EW   = exp_width(XLEN);
  localparam int MW   = XLEN - 1 - EW;
  localparam int EMAX = (1 << EW) - 1;
  localparam int G    = 3;
  localparam int S    = MW + G + 2;

  logic            w_swap, w_sub;
  logic [XLEN-1:0] w_big, w_small;
  logic [EW-1:0]   w_eb, w_es;
  logic [S-1:0]    w_mb, w_ms, w_sum, w_norm;
  int              w_p, w_exp;
  logic            w_unused;

  assign w_unused = ^{w_norm[S-1], w_norm[G-1:0]};

  always_comb begin
    // Order by magnitude so the aligned subtraction never goes negative.
    w_swap  = i_b[XLEN-2:0] > i_a[XLEN-2:0];
    w_big   = w_swap ? i_b : i_a;
    w_small = w_swap ? i_a : i_b;
    w_eb    = w_big[XLEN-2 -: EW];
    w_es    = w_small[XLEN-2 -: EW];
    w_mb    = {1'b0, w_eb != '0, w_big[MW-1:0], {G{1'b0}}};
    w_ms    = {1'b0, w_es != '0, w_small[MW-1:0], {G{1'b0}}} >> (w_eb - w_es);
    w_sub   = w_big[XLEN-1] ^ w_small[XLEN-1];
    w_sum   = w_sub ? (w_mb - w_ms) : (w_mb + w_ms);
    w_p     = 0;
    for (int i = 0; i < S; i++) begin
      if (w_sum[i]) w_p = i;
    end
    w_norm   = w_sum << (S - 1 - w_p);
    w_exp    = int'(w_eb) + w_p - (S - 2);
    o_result = {w_big[XLEN-1], EW'(w_exp), w_norm[S-2 -: MW]};
    if (w_eb == '1) begin
      if (w_big[MW-1:0] != '0 || (w_es == '1 && w_sub))
        o_result = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
      else
        o_result = {w_big[XLEN-1], {EW{1'b1}}, {MW{1'b0}}};
    end else if (w_sum == '0 || w_exp <= 0) begin
      o_result = '0;
    end else if (w_exp >= EMAX) begin
      o_result = {w_big[XLEN-1], {EW{1'b1}}, {MW{1'b0}}};
    end
  end
endmodule

// File: rtl/pipelined_processing_unit.sv
// LANES-wide floating-point dot product: product stage, registered adder tree, accumulator.
// Optional RELU_EN clamps every result with its sign bit set to +0.0.
module pipelined_processing_unit import pu_pkg::*; #(
  parameter int XLEN  = 32,
  parameter int LANES = 4,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  pu_if.slave        bus,
  output acc_state_t dbg_acc_state
);
  localparam int TL = tree_levels(LANES);

  logic                  w_adv;
  logic [LANES*XLEN-1:0] w_prod;
  logic [LANES*XLEN-1:0] r_prod;
  logic                  r_m_valid, r_m_last;
  logic [XLEN-1:0]       w_tree, w_acc_sum, w_load, w_result_next;
  logic                  w_tree_valid, w_tree_last;
  logic [CNT_W-1:0]      w_cnt_inc;
  acc_state_t            r_state;
  logic [XLEN-1:0]       r_acc, r_result;
  logic                  r_out_valid;
  logic [CNT_W-1:0]      r_beat_count;

  // Single enable for every stage: a held result freezes the whole pipe.
  assign w_adv        = !r_out_valid || bus.out_ready;
  assign bus.in_ready = w_adv;

  for (genvar i = 0; i < LANES; i++) begin : g_mul
    FloatingMultiplication #(.XLEN(XLEN)) u_mul (
      .i_a      (`PU_LANE(bus.in_num, i, XLEN)),
      .i_b      (`PU_LANE(bus.in_weight, i, XLEN)),
      .o_result (`PU_LANE(w_prod, i, XLEN))
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prod    <= '0;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
    end else if (w_adv) begin
      r_prod    <= w_prod;
      r_m_valid <= bus.in_valid;
      r_m_last  <= bus.in_last;
    end
  end

  for (genvar k = 0; k < TL; k++) begin : g_lvl
    logic [(LANES>>k)*XLEN-1:0]     w_in;
    logic                           w_vin, w_lin;
    logic [(LANES>>(k+1))*XLEN-1:0] w_out;
    logic                           w_vout, w_lout;
    if (k == 0) begin : g_first
      assign w_in  = r_prod;
      assign w_vin = r_m_valid;
      assign w_lin = r_m_last;
    end else begin : g_next
      assign w_in  = g_lvl[k-1].w_out;
      assign w_vin = g_lvl[k-1].w_vout;
      assign w_lin = g_lvl[k-1].w_lout;
    end
    fp_adder_tree_level #(.XLEN(XLEN), .N_IN(LANES >> k)) u_level (
      .clk     (clk),
      .rst     (rst),
      .i_en    (w_adv),
      .i_data  (w_in),
      .i_valid (w_vin),
      .i_last  (w_lin),
      .o_data  (w_out),
      .o_valid (w_vout),
      .o_last  (w_lout)
    );
  end

  assign w_tree       = g_lvl[TL-1].w_out;
  assign w_tree_valid = g_lvl[TL-1].w_vout;
  assign w_tree_last  = g_lvl[TL-1].w_lout;

  FloatingAddition #(.XLEN(XLEN)) u_acc_add (
    .i_a      (r_acc),
    .i_b      (w_tree),
    .o_result (w_acc_sum)
  );

  assign w_load    = (r_state == ACC_EMPTY) ? w_tree : w_acc_sum;
  assign w_cnt_inc = (r_beat_count == '1) ? r_beat_count : r_beat_count + 1'b1;

`ifdef RELU_EN
  assign w_result_next = w_load[XLEN-1] ? FP_ZERO[XLEN-1:0] : w_load;
`else
  assign w_result_next = w_load;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ACC_EMPTY;
      r_acc        <= FP_ZERO[XLEN-1:0];
      r_result     <= FP_ZERO[XLEN-1:0];
      r_out_valid  <= 1'b0;
      r_beat_count <= '0;
    end else if (w_adv) begin
      r_out_valid <= w_tree_valid && w_tree_last;
      if (w_tree_valid) begin
        case (r_state)
          ACC_EMPTY: begin
            r_beat_count <= CNT_W'(1);
            if (w_tree_last) begin
              r_result <= w_result_next;
            end else begin
              r_acc   <= w_tree;
              r_state <= ACC_BUSY;
            end
          end
          default: begin
            r_beat_count <= w_cnt_inc;
            if (w_tree_last) begin
              r_result <= w_result_next;
              r_acc    <= FP_ZERO[XLEN-1:0];
              r_state  <= ACC_EMPTY;
            end else begin
              r_acc <= w_acc_sum;
            end
          end
        endcase
      end
    end
  end

  assign bus.result     = r_result;
  assign bus.out_valid  = r_out_valid;
  assign bus.beat_count = r_beat_count;
  assign dbg_acc_state  = r_state;
endmodule

// File: doc/pipelined_processing_unit.md
Name: pipelined_processing_unit

Overview:
- Parametrised successor to the fixed 4-input processing unit: LANES-wide floating-point dot product with a registered adder tree, multi-beat accumulation and a valid/ready handshake on both sides.
- Sits between the Maxnet weight/activation feeders and the comparator/update logic.
- Reuses the existing combinational FloatingMultiplication and FloatingAddition cores.

Parameters:
- XLEN, 32, float word width; IEEE-754 single for 32.
- LANES, 4, products per beat; power of two, 2..16.
- CNT_W, 8, width of the saturating beat counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_num  in  LANES*XLEN  operand lanes; lane i is bits [i*XLEN +: XLEN].
- in_weight  in  LANES*XLEN  weight lanes, same packing.
- in_valid  in  1  beat offered.
- in_last  in  1  final beat of the current dot product.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- result  out  XLEN  accumulated dot product.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- beat_count  out  CNT_W  beats accumulated into the current/last result; saturates at all-ones.

Behaviour:
- Reset (rst=0, async): all pipeline data regs, acc, result and beat_count = 0; all stage valids, out_valid and acc state = 0 (EMPTY).
- Pipeline layout:
  - Stage M registers LANES products.
  - log2(LANES) tree levels, each one registered FloatingAddition level.
  - Stage A (accumulator/output).
  - Each stage carries valid and last.
- Global enable: adv = !out_valid || out_ready; in_ready = adv. When adv=0 every register holds (full stall, no bubbles collapse).
- Latency: accepted last beat -> out_valid after exactly log2(LANES)+2 cycles with no stall. Throughput: 1 beat/cycle.
- Accumulator FSM, evaluated when adv and tree-output valid:
  - EMPTY, last=0: acc <= tree; beat_count <= 1; -> BUSY.
  - EMPTY, last=1: result <= tree; out_valid <= 1; beat_count <= 1; stay EMPTY.
  - BUSY, last=0: acc <= acc + tree; beat_count++ (saturating); stay BUSY.
  - BUSY, last=1: result <= acc + tree; out_valid <= 1; acc <= 0; beat_count++; -> EMPTY.
- out_valid clears when out_ready && no new result completes that cycle. Back-to-back results keep out_valid high.
- result and beat_count are stable while out_valid && !out_ready.
- Bubbles (invalid stage data) never touch acc or beat_count.
- Float arithmetic semantics, rounding and special values are exactly those of the shared multiply/add cores; no extra normalisation.
- A reset asserted mid-stream discards all in-flight beats and the partial accumulation; no result is emitted.

Optional Feature:
- RELU_EN defined: when loading result, a sign bit of 1 (including -0 and negative values) yields result = 0 (+0.0); beat_count is unaffected.
- Undefined: result is passed signed.

Decomposition:
- Shared package pu_pkg holds:
  - FP_ZERO constant.
  - clog2 helper / TREE_LEVELS constant.
  - lane-slice macro/function.
  - acc_state_t enum {ACC_EMPTY, ACC_BUSY}.
- One natural sub-module: fp_adder_tree_level. It holds LANES/2^k FloatingAddition instances plus a registered valid/last, with the stall enable as input; instantiated per level via generate.

Test Plan:
- LANES=4, all nums 1.0 (3F800000), weights 2.0 (40000000), single beat last=1 -> result 41000000 (8.0) exactly 4 cycles after handshake; beat_count=1.
- Three beats (last on third), nums 1.0, weights 0.5 (3F000000) -> one result 40C00000 (6.0), beat_count=3, no output on beats 1-2.
- Hold out_ready=0 with a result pending while streaming -> in_ready=0, result stays stable; raise out_ready -> next result follows with no lost or duplicated beats.
- Weights -1.0 (BF800000), nums 1.0, single beat -> C0800000 (-4.0); with RELU_EN -> 00000000.
- Assert rst during a BUSY accumulation, release, send one last beat of 1.0x1.0 -> result 40800000 (4.0) and beat_count=1, with no stale acc contribution.
- 300 beats before last with CNT_W=8 -> beat_count saturates at FF.
